// File: rtl/cla_pkg.sv
// cla_pkg: shared widths and operand/sum types for the CLA adder datapath
package cla_pkg;
    localparam int CLA_W = 15;
    localparam int CLA_SUM_W = CLA_W + 1;
    typedef logic [CLA_W-1:0] cla_op_t;
    typedef logic [CLA_SUM_W-1:0] cla_sum_t;
endpackage

// File: rtl/cla_add_pipe_if.sv
// cla_add_pipe_if: operand-in / sum-out valid-ready bus of the pipelined adder
interface cla_add_pipe_if #(
    parameter int WIDTH = 15,
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add1;
    logic [WIDTH-1:0] i_add2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic [CNT_W-1:0] o_count;
    modport master (
        output i_valid, i_add1, i_add2, i_ready,
        input  o_ready, o_valid, o_result, o_count
    );
    modport slave (
        input  i_valid, i_add1, i_add2, i_ready,
        output o_ready, o_valid, o_result, o_count
    );
endinterface

// File: rtl/cla_15bit.sv
// cla_15bit: combinational carry-lookahead adder, 4-bit lookahead groups rippling group carries
module cla_15bit
    import cla_pkg::*;
(
    input  cla_op_t  a,
    input  cla_op_t  b,
    output cla_sum_t s
);
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = 1'b0;
    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        // the top group only has three bits; its last carry is the adder carry-out
        if (k < 3) begin : g_full
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B])
                          | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end
    assign s = {c[CLA_W], p ^ c[CLA_W-1:0]};
endmodule

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage valid/ready wrapper (operand reg -> CLA core -> result reg)
module cla_add_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int CNT_W = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cla_add_pipe_if.slave  bus
);
    if (WIDTH != CLA_W) begin : g_width_check
        $error("cla_add_pipe: WIDTH must equal CLA_W");
    end
    cla_op_t  s1_add1;
    cla_op_t  s1_add2;
    cla_sum_t sum;
    logic     s1_valid;
    logic     accept;
    logic     move;
    assign bus.o_ready = !s1_valid || !bus.o_valid || bus.i_ready;
    assign accept = bus.i_valid && bus.o_ready;
    assign move = s1_valid && (!bus.o_valid || bus.i_ready);
    cla_15bit u_core (
        .a(s1_add1),
        .b(s1_add2),
        .s(sum)
    );
    // operand stage: capture on accept, stay full while the result stage is blocked
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_add1 <= '0;
            s1_add2 <= '0;
            bus.o_count <= '0;
        end else begin
            s1_valid <= accept || (s1_valid && !move);
            if (accept) begin
                s1_add1 <= bus.i_add1;
                s1_add2 <= bus.i_add2;
                bus.o_count <= bus.o_count + CNT_W'(1);
            end
        end
    end
    // result stage: load the core sum when free or draining, hold it under backpressure
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_valid <= 1'b0;
            bus.o_result <= '0;
        end else begin
            bus.o_valid <= move || (bus.o_valid && !bus.i_ready);
            if (move) bus.o_result <= sum;
        end
    end
endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: directed vectors with a scoreboard queue checked by a separate monitor
module tb_cla_add_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] q[$];
    logic [15:0] exp_in = '0;
    logic        prev_stall;
    logic [15:0] prev_res;

    cla_add_pipe_if #(.WIDTH(15), .CNT_W(16)) bus ();

    cla_add_pipe #(.WIDTH(15), .CNT_W(16)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [14:0] a, input logic [14:0] b,
                          input logic [15:0] e, input logic r);
        bus.i_valid = v;
        bus.i_add1 = a;
        bus.i_add2 = b;
        bus.i_ready = r;
        exp_in = e;
    endtask

    // monitor: inputs change only on negedge, so negedge+1 sees what the next posedge will act on
    initial begin
        prev_stall = 1'b0;
        prev_res = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.o_valid), 1);
                    check("hold_result", 32'(bus.o_result), 32'(prev_res));
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (q.size() == 0) check("spurious_out", q.size(), 1);
                    else check("sb_result", 32'(bus.o_result), 32'(q.pop_front()));
                end
                if (bus.i_valid && bus.o_ready) q.push_back(exp_in);
                prev_stall = bus.o_valid && !bus.i_ready;
                prev_res = bus.o_result;
            end
        end
    end

    initial begin
        set_in(1'b0, '0, '0, '0, 1'b1);
        // reset held, then released idle
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_result", 32'(bus.o_result), 0);
        check("rst_count", 32'(bus.o_count), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(bus.o_ready), 1);
        check("rel_valid", 32'(bus.o_valid), 0);
        // single pair, two-cycle latency
        @(negedge clk);
        set_in(1'b1, 15'h7fff, 15'h7fff, 16'hfffe, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, '0, '0, 1'b1);
        #1;
        check("lat1_valid", 32'(bus.o_valid), 0);
        @(negedge clk);
        #1;
        check("lat2_valid", 32'(bus.o_valid), 1);
        check("lat2_result", 32'(bus.o_result), 32'h fffe);
        check("count1", 32'(bus.o_count), 1);
        // back-to-back stream
        @(negedge clk);
        set_in(1'b1, 15'h7fff, 15'h0001, 16'h8000, 1'b1);
        @(negedge clk);
        set_in(1'b1, 15'h0000, 15'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        set_in(1'b1, 15'h1234, 15'h4321, 16'h5555, 1'b1);
        #1;
        check("stream0_valid", 32'(bus.o_valid), 1);
        check("stream0_result", 32'(bus.o_result), 32'h8000);
        @(negedge clk);
        set_in(1'b0, '0, '0, '0, 1'b1);
        #1;
        check("stream1_valid", 32'(bus.o_valid), 1);
        check("stream1_result", 32'(bus.o_result), 32'h0000);
        @(negedge clk);
        #1;
        check("stream2_valid", 32'(bus.o_valid), 1);
        check("stream2_result", 32'(bus.o_result), 32'h5555);
        @(negedge clk);
        #1;
        check("stream_end_valid", 32'(bus.o_valid), 0);
        check("count4", 32'(bus.o_count), 4);
        // backpressure: two pairs fill the pipe, third is refused until i_ready rises
        @(negedge clk);
        set_in(1'b1, 15'h1111, 15'h2222, 16'h3333, 1'b0);
        @(negedge clk);
        set_in(1'b1, 15'h4000, 15'h4000, 16'h8000, 1'b0);
        @(negedge clk);
        set_in(1'b1, 15'h0fff, 15'h0001, 16'h1000, 1'b0);
        #1;
        check("full_ready", 32'(bus.o_ready), 0);
        check("full_valid", 32'(bus.o_valid), 1);
        check("full_result", 32'(bus.o_result), 32'h3333);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("stall_ready", 32'(bus.o_ready), 0);
            check("stall_result", 32'(bus.o_result), 32'h3333);
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1;
        check("drain_ready", 32'(bus.o_ready), 1);
        @(negedge clk);
        set_in(1'b0, '0, '0, '0, 1'b1);
        #1;
        check("drain1_result", 32'(bus.o_result), 32'h8000);
        @(negedge clk);
        #1;
        check("drain2_result", 32'(bus.o_result), 32'h1000);
        @(negedge clk);
        #1;
        check("drain_end_valid", 32'(bus.o_valid), 0);
        check("count7", 32'(bus.o_count), 7);
        check("drain_queue", q.size(), 0);
        // reset with both stages full
        @(negedge clk);
        set_in(1'b1, 15'h0001, 15'h0002, 16'h0003, 1'b0);
        @(negedge clk);
        set_in(1'b1, 15'h0005, 15'h0006, 16'h000b, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, '0, '0, 1'b0);
        #1;
        check("prerst_valid", 32'(bus.o_valid), 1);
        check("prerst_ready", 32'(bus.o_ready), 0);
        check("prerst_count", 32'(bus.o_count), 9);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 0);
        check("midrst_result", 32'(bus.o_result), 0);
        check("midrst_count", 32'(bus.o_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, '0, '0, '0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("postrst_valid", 32'(bus.o_valid), 0);
        end
        // counter wrap after 2^16+3 accepts at full throughput
        for (int i = 0; i < 65539; i++) begin
            @(negedge clk);
            set_in(1'b1, 15'(i), 15'(i * 3), {1'b0, 15'(i)} + {1'b0, 15'(i * 3)}, 1'b1);
        end
        @(negedge clk);
        set_in(1'b0, '0, '0, '0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_count", 32'(bus.o_count), 3);
        check("wrap_valid", 32'(bus.o_valid), 0);
        check("wrap_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
